look_up_nanofs_header: RTL and testbench
========================================

# look_up_nanofs_header

Reads the nanofs header block at the start of the boot partition, validates its magic, and extracts the file layout for the loader. Sits directly downstream of the MBR partition lookup: its `part_start` input is that stage's partition-start LBA, and its `success` pulse chain starts this block. It shares the same SPI block/byte read controller, muxed by the top level. Its outputs feed the block-copy stage that streams the image into memory.

## Interface
Parameters:
- None. The header layout and the 512-byte block size are fixed.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  level or pulse. Sampled only in IDLE.
- `part_start`  in  32  partition start LBA. Latched when `start` is accepted.
- `success`  out  1  high while in SUCCESS.
- `err_signal`  out  1  high while in ERROR.
- `err_code`  out  2  0 = none, 1 = SPI error, 2 = bad magic, 3 = empty file. Registered.
- `data_start_block`  out  32  absolute LBA of the first file data block. Registered.
- `file_size`  out  32  file size in bytes, little-endian header field. Registered.
- `num_blocks`  out  24  ceil(`file_size`/512). Registered.
- `spi_r_block`  out  1  block-read request, held for the whole block.
- `spi_r_byte`  out  1  one-cycle byte-fetch pulse.
- `spi_busy`  in  1  controller busy.
- `spi_err`  in  1  controller error.
- `spi_block_addr`  out  32  latched `part_start`.
- `spi_data_out`  in  8  byte from controller. Valid when `spi_busy` is low after a byte fetch.
- `debug_leds`  out  4  current state encoding.

## Operation
Header layout within partition block 0 (byte index, little-endian):
- Bytes 0–3: magic 0x4E 0x41 0x4E 0x4F ("NANO").
- Bytes 4–7: data offset, in blocks, relative to the partition start.
- Bytes 8–11: file size in bytes.
- Bytes 12–511: read and discarded.

State machine:
- IDLE (0x0): clears the byte counter, magic/offset/size registers and `err_code`. On `start`, latches `part_start` and goes to WAIT_SPI.
- WAIT_SPI (0x1): when `spi_busy` is 0, goes to READ_BLOCK.
- READ_BLOCK (0x2): asserts `spi_r_block`. Goes to WAIT_BLOCK.
- WAIT_BLOCK (0x3): asserts `spi_r_block`. When `spi_busy` is 0, goes to READ_BYTE.
- READ_BYTE (0x4): asserts `spi_r_block` and `spi_r_byte`. Goes to WAIT_BYTE.
- WAIT_BYTE (0x5): asserts `spi_r_block`. When `spi_busy` is 0, goes to STORE_BYTE.
- STORE_BYTE (0x6): asserts `spi_r_block`. Writes `spi_data_out` into the byte slot selected by `byte_idx` (0–11) and increments `byte_idx`. If `byte_idx` was 511, goes to CHECK; otherwise goes to READ_BYTE.
- CHECK (0x7): evaluates in priority order:
  - magic ≠ "NANO" → `err_code` = 2, go to ERROR;
  - otherwise size = 0 → `err_code` = 3, go to ERROR;
  - otherwise → go to SUCCESS.
  - In every case it registers `data_start_block` = latched `part_start` + offset (mod 2^32, carry discarded), `file_size`, and `num_blocks` = size[31:9] + (size[8:0] ≠ 0).
- SUCCESS (0x8) and ERROR (0x9) are terminal; only `reset` leaves them. `spi_r_block` is 0 in both.
- `spi_err` = 1 in any of states 0x1–0x6 → `err_code` = 1 and go to ERROR next cycle. This takes priority over every other transition.
- Unused encodings: go to ERROR with `err_code` = 1.

## Timing
- Reset value of every output is 0: `success`, `err_signal`, `err_code`, `data_start_block`, `file_size`, `num_blocks`, `spi_r_block`, `spi_r_byte`. `spi_block_addr` also resets to 0, and the state resets to IDLE.
- Reset mid-read: the state is IDLE on the next edge, so `spi_r_block` and `spi_r_byte` are low from that edge. The controller abort is owned by the controller.
- All SPI request outputs are combinational decodes of the state; there is no extra registering.
- Controller contract: `spi_busy` is high in the cycle after a READ_BLOCK or READ_BYTE request. WAIT states therefore never exit in their first cycle on a stale low.
- Zero-wait latency from `start` accepted to `success`: 1 + 1 + 1 + 3×512 + 1 = 1540 cycles.
- `start` held high while in SUCCESS or ERROR has no effect.
- Every byte index 0–511 is fetched exactly once; exactly 512 `spi_r_byte` pulses occur per run.

## Test plan
- Valid header: `part_start` = 0x00000800, offset = 4, size = 0x00000401. Required: `success` = 1, `data_start_block` = 0x804, `num_blocks` = 3, `err_code` = 0, 512 byte pulses, latency 1540 with a zero-wait model.
- Bad magic: bytes 0–3 = "NANX". Required: `err_signal` = 1, `err_code` = 2, `success` never 1.
- Empty file: good magic, size = 0. Required: `err_code` = 3. Size = 0x200 with good magic: `num_blocks` = 1.
- Wrap-around: `part_start` = 0xFFFFFFFE, offset = 3. Required: `data_start_block` = 0x00000001. Size = 0xFFFFFFFF: `num_blocks` = 0x800000.
- SPI error: `spi_err` pulsed during WAIT_BYTE at byte 100. Required: ERROR next cycle, `err_code` = 1, `spi_r_block` = 0.
- Reset asserted at byte 300, then `start` again with a valid header. Required: all outputs 0 after reset, and the second run completes with correct values.

Source files
------------

// File: rtl/look_up_nanofs_header_if.sv
// Signal bundle between the nanofs header reader, its upstream/downstream
// stages and the shared SPI block/byte read controller.
interface look_up_nanofs_header_if;
    logic        start;
    logic [31:0] part_start;
    logic        success;
    logic        err_signal;
    logic [1:0]  err_code;
    logic [31:0] data_start_block;
    logic [31:0] file_size;
    logic [23:0] num_blocks;
    logic        spi_r_block;
    logic        spi_r_byte;
    logic        spi_busy;
    logic        spi_err;
    logic [31:0] spi_block_addr;
    logic [7:0]  spi_data_out;
    logic [3:0]  debug_leds;

    modport slave (
        input  start, part_start, spi_busy, spi_err, spi_data_out,
        output success, err_signal, err_code, data_start_block, file_size,
               num_blocks, spi_r_block, spi_r_byte, spi_block_addr, debug_leds
    );

    modport master (
        output start, part_start, spi_busy, spi_err, spi_data_out,
        input  success, err_signal, err_code, data_start_block, file_size,
               num_blocks, spi_r_block, spi_r_byte, spi_block_addr, debug_leds
    );
endinterface

// File: rtl/look_up_nanofs_header.sv
// Reads partition block 0, checks the "NANO" magic and extracts the data
// offset and file size for the block-copy stage.
module look_up_nanofs_header (
    input  logic                        clk,
    input  logic                        reset,
    look_up_nanofs_header_if.slave      bus
);

    typedef enum logic [3:0] {
        IDLE       = 4'h0,
        WAIT_SPI   = 4'h1,
        READ_BLOCK = 4'h2,
        WAIT_BLOCK = 4'h3,
        READ_BYTE  = 4'h4,
        WAIT_BYTE  = 4'h5,
        STORE_BYTE = 4'h6,
        CHECK      = 4'h7,
        SUCCESS    = 4'h8,
        ERROR      = 4'h9
    } state_e;

    localparam logic [31:0] MAGIC_NANO = 32'h4F4E414E;

    state_e      state_q, state_d;
    logic [8:0]  byte_idx_q, byte_idx_d;
    logic [31:0] magic_q, magic_d;
    logic [31:0] offset_q, offset_d;
    logic [31:0] size_q, size_d;
    logic [31:0] block_addr_q, block_addr_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] data_start_q, data_start_d;
    logic [31:0] file_size_q, file_size_d;
    logic [23:0] num_blocks_q, num_blocks_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            magic_q      <= '0;
            offset_q     <= '0;
            size_q       <= '0;
            block_addr_q <= '0;
            err_code_q   <= '0;
            data_start_q <= '0;
            file_size_q  <= '0;
            num_blocks_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            magic_q      <= magic_d;
            offset_q     <= offset_d;
            size_q       <= size_d;
            block_addr_q <= block_addr_d;
            err_code_q   <= err_code_d;
            data_start_q <= data_start_d;
            file_size_q  <= file_size_d;
            num_blocks_q <= num_blocks_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        magic_d      = magic_q;
        offset_d     = offset_q;
        size_d       = size_q;
        block_addr_d = block_addr_q;
        err_code_d   = err_code_q;
        data_start_d = data_start_q;
        file_size_d  = file_size_q;
        num_blocks_d = num_blocks_q;

        case (state_q)
            IDLE: begin
                byte_idx_d = '0;
                magic_d    = '0;
                offset_d   = '0;
                size_d     = '0;
                err_code_d = 2'd0;
                if (bus.start) begin
                    block_addr_d = bus.part_start;
                    state_d      = WAIT_SPI;
                end
            end
            WAIT_SPI:   if (!bus.spi_busy) state_d = READ_BLOCK;
            READ_BLOCK: state_d = WAIT_BLOCK;
            WAIT_BLOCK: if (!bus.spi_busy) state_d = READ_BYTE;
            READ_BYTE:  state_d = WAIT_BYTE;
            WAIT_BYTE:  if (!bus.spi_busy) state_d = STORE_BYTE;
            STORE_BYTE: begin
                // Only bytes 0-11 carry header fields; the rest of the block is drained.
                case (byte_idx_q[8:2])
                    7'd0:    magic_d[{byte_idx_q[1:0], 3'b000} +: 8]  = bus.spi_data_out;
                    7'd1:    offset_d[{byte_idx_q[1:0], 3'b000} +: 8] = bus.spi_data_out;
                    7'd2:    size_d[{byte_idx_q[1:0], 3'b000} +: 8]   = bus.spi_data_out;
                    default: ;
                endcase
                byte_idx_d = byte_idx_q + 9'd1;
                state_d    = (byte_idx_q == 9'd511) ? CHECK : READ_BYTE;
            end
            CHECK: begin
                data_start_d = block_addr_q + offset_q;
                file_size_d  = size_q;
                num_blocks_d = {1'b0, size_q[31:9]} + {23'd0, |size_q[8:0]};
                if (magic_q != MAGIC_NANO) begin
                    err_code_d = 2'd2;
                    state_d    = ERROR;
                end else if (size_q == 32'd0) begin
                    err_code_d = 2'd3;
                    state_d    = ERROR;
                end else begin
                    state_d = SUCCESS;
                end
            end
            SUCCESS: state_d = SUCCESS;
            ERROR:   state_d = ERROR;
            default: begin
                err_code_d = 2'd1;
                state_d    = ERROR;
            end
        endcase

        // A controller error aborts any in-flight read, overriding the normal flow.
        if (bus.spi_err && (state_q >= WAIT_SPI) && (state_q <= STORE_BYTE)) begin
            err_code_d = 2'd1;
            state_d    = ERROR;
        end
    end

    assign bus.success          = (state_q == SUCCESS);
    assign bus.err_signal       = (state_q == ERROR);
    assign bus.err_code         = err_code_q;
    assign bus.data_start_block = data_start_q;
    assign bus.file_size        = file_size_q;
    assign bus.num_blocks       = num_blocks_q;
    assign bus.spi_r_block      = (state_q >= READ_BLOCK) && (state_q <= STORE_BYTE);
    assign bus.spi_r_byte       = (state_q == READ_BYTE);
    assign bus.spi_block_addr   = block_addr_q;
    assign bus.debug_leds       = state_q;

endmodule

// File: tb/tb_look_up_nanofs_header.sv
// Bench for look_up_nanofs_header: a behavioural SPI controller serves a header
// image, and results are compared against values derived from the image bytes.
module tb_look_up_nanofs_header;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    look_up_nanofs_header_if hdr();

    look_up_nanofs_header dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hdr)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] img [512];
    int         waitCycles = 0;
    int         busyCnt    = 0;
    int         pulseCnt   = 0;
    logic       prevBlock  = 1'b0;

    // SPI controller model: busy for waitCycles after each request, byte valid once idle.
    always @(negedge clk) begin
        if (reset || hdr.debug_leds == 4'h0) begin
            pulseCnt = 0;
            busyCnt  = 0;
        end else if (hdr.spi_r_byte) begin
            hdr.spi_data_out = img[pulseCnt % 512];
            pulseCnt = pulseCnt + 1;
            busyCnt  = waitCycles;
        end else if (hdr.spi_r_block && !prevBlock) begin
            busyCnt = waitCycles;
        end else if (busyCnt > 0) begin
            busyCnt = busyCnt - 1;
        end
        prevBlock    = hdr.spi_r_block;
        hdr.spi_busy = (busyCnt != 0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic buildImage(input logic [31:0] magic, input logic [31:0] offset, input logic [31:0] size);
        for (int i = 0; i < 512; i++) img[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            img[i]     = magic[8*i +: 8];
            img[4 + i] = offset[8*i +: 8];
            img[8 + i] = size[8*i +: 8];
        end
    endtask

    task automatic applyStimulus(input logic [31:0] part, input int waits, input bit holdStart);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset          = 1'b0;
        waitCycles     = waits;
        hdr.part_start = part;
        hdr.start      = 1'b1;
        @(negedge clk);
        if (!holdStart) hdr.start = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output bit sawSuccess, output bit timedOut);
        cycles     = 0;
        sawSuccess = 1'b0;
        timedOut   = 1'b0;
        while (!(hdr.success || hdr.err_signal)) begin
            if (cycles > 20000) begin
                timedOut = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
            if (hdr.success) sawSuccess = 1'b1;
        end
    endtask

    task automatic checkResult(input string tag, input logic [31:0] part, input bit timedOut, input bit sawSuccess);
        logic        magicOk;
        logic [31:0] off, size;
        logic [1:0]  expErr;
        logic [63:0] blocks;
        magicOk = (img[0] == 8'h4E) && (img[1] == 8'h41) && (img[2] == 8'h4E) && (img[3] == 8'h4F);
        off     = {img[7], img[6], img[5], img[4]};
        size    = {img[11], img[10], img[9], img[8]};
        expErr  = !magicOk ? 2'd2 : (size == 0) ? 2'd3 : 2'd0;
        blocks  = (64'(size) + 64'd511) / 64'd512;
        checkOutput({tag, ".timeout"},    32'(timedOut),          32'd0);
        checkOutput({tag, ".success"},    32'(hdr.success),       32'(expErr == 0));
        checkOutput({tag, ".everSucc"},   32'(sawSuccess),        32'(expErr == 0));
        checkOutput({tag, ".errSignal"},  32'(hdr.err_signal),    32'(expErr != 0));
        checkOutput({tag, ".errCode"},    32'(hdr.err_code),      32'(expErr));
        checkOutput({tag, ".dataStart"},  hdr.data_start_block,   part + off);
        checkOutput({tag, ".fileSize"},   hdr.file_size,          size);
        checkOutput({tag, ".numBlocks"},  32'(hdr.num_blocks),    blocks[31:0]);
        checkOutput({tag, ".bytePulses"}, 32'(pulseCnt),          32'd512);
        checkOutput({tag, ".blockAddr"},  hdr.spi_block_addr,     part);
        checkOutput({tag, ".rBlockIdle"}, 32'(hdr.spi_r_block),   32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".success"},   32'(hdr.success),     32'd0);
        checkOutput({tag, ".errSignal"}, 32'(hdr.err_signal),  32'd0);
        checkOutput({tag, ".errCode"},   32'(hdr.err_code),    32'd0);
        checkOutput({tag, ".dataStart"}, hdr.data_start_block, 32'd0);
        checkOutput({tag, ".fileSize"},  hdr.file_size,        32'd0);
        checkOutput({tag, ".numBlocks"}, 32'(hdr.num_blocks),  32'd0);
        checkOutput({tag, ".rBlock"},    32'(hdr.spi_r_block), 32'd0);
        checkOutput({tag, ".rByte"},     32'(hdr.spi_r_byte),  32'd0);
        checkOutput({tag, ".blockAddr"}, hdr.spi_block_addr,   32'd0);
        checkOutput({tag, ".state"},     32'(hdr.debug_leds),  32'd0);
    endtask

    task automatic runFull(input string tag, input logic [31:0] part, input int waits);
        int cycles;
        bit saw, tout;
        applyStimulus(part, waits, 1'b0);
        waitDone(cycles, saw, tout);
        checkResult(tag, part, tout, saw);
    endtask

    task automatic waitPulses(input string tag, input int count, input logic [3:0] state);
        int budget = 0;
        while (!(pulseCnt == count && hdr.debug_leds == state) && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        checkOutput({tag, ".reached"}, 32'(budget < 20000), 32'd1);
    endtask

    localparam logic [31:0] GOOD = 32'h4F4E414E;
    localparam logic [31:0] NANX = 32'h584E414E;

    initial begin
        int cycles;
        bit saw, tout;
        logic [31:0] part, off, size, magic;

        reset            = 1'b1;
        hdr.start        = 1'b0;
        hdr.part_start   = '0;
        hdr.spi_err      = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;

        $display("[TB] valid header, zero-wait, start held high");
        buildImage(GOOD, 32'd4, 32'h401);
        applyStimulus(32'h800, 0, 1'b1);
        waitDone(cycles, saw, tout);
        checkResult("valid", 32'h800, tout, saw);
        checkOutput("valid.latency", 32'(cycles), 32'd1540);
        checkOutput("valid.dsbConst", hdr.data_start_block, 32'h804);
        checkOutput("valid.nbConst", 32'(hdr.num_blocks), 32'd3);
        repeat (5) @(negedge clk);
        checkOutput("valid.holdState", 32'(hdr.debug_leds), 32'h8);
        checkOutput("valid.holdPulses", 32'(pulseCnt), 32'd512);
        hdr.start = 1'b0;

        $display("[TB] directed corner cases");
        buildImage(NANX, 32'd4, 32'h401);
        runFull("badMagic", 32'h800, 2);
        checkOutput("badMagic.code", 32'(hdr.err_code), 32'd2);
        buildImage(GOOD, 32'd7, 32'd0);
        runFull("empty", 32'h1000, 1);
        checkOutput("empty.code", 32'(hdr.err_code), 32'd3);
        buildImage(GOOD, 32'd1, 32'h200);
        runFull("oneBlock", 32'h20, 0);
        checkOutput("oneBlock.nb", 32'(hdr.num_blocks), 32'd1);
        buildImage(GOOD, 32'd3, 32'hFFFFFFFF);
        runFull("wrap", 32'hFFFFFFFE, 1);
        checkOutput("wrap.dsb", hdr.data_start_block, 32'h1);
        checkOutput("wrap.nb", 32'(hdr.num_blocks), 32'h800000);

        $display("[TB] spi error during byte 100");
        buildImage(GOOD, 32'd4, 32'h401);
        applyStimulus(32'h800, 2, 1'b0);
        waitPulses("spiErr", 101, 4'h5);
        hdr.spi_err = 1'b1;
        @(negedge clk);
        hdr.spi_err = 1'b0;
        checkOutput("spiErr.state", 32'(hdr.debug_leds), 32'h9);
        checkOutput("spiErr.errSignal", 32'(hdr.err_signal), 32'd1);
        checkOutput("spiErr.code", 32'(hdr.err_code), 32'd1);
        checkOutput("spiErr.rBlock", 32'(hdr.spi_r_block), 32'd0);
        checkOutput("spiErr.success", 32'(hdr.success), 32'd0);

        $display("[TB] reset at byte 300 then rerun");
        applyStimulus(32'h800, 1, 1'b0);
        waitPulses("midReset", 301, 4'h5);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("midReset");
        reset = 1'b0;
        runFull("afterReset", 32'h800, 0);

        $display("[TB] randomized headers");
        for (int n = 0; n < 6; n++) begin
            part  = $urandom;
            off   = $urandom;
            case ($urandom_range(0, 3))
                0:       size = 32'd0;
                1:       size = 32'($urandom_range(1, 1500));
                default: size = $urandom;
            endcase
            magic = GOOD;
            if ($urandom_range(0, 3) == 0) magic = GOOD ^ (32'd1 << $urandom_range(0, 31));
            buildImage(magic, off, size);
            runFull($sformatf("rand%0d", n), part, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
